// File: rtl/jk_pkg.sv
// Shared types and the result predictor for the JK operation arbiter.
// jk_expected works on JK_MAX_W-bit vectors; callers zero-extend and truncate.
package jk_pkg;

  localparam int JK_MAX_W = 32;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_CLR    = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK
  } state_t;

  // Predicted Q after one JK clock: unmasked bits keep their snapshot value.
  function automatic logic [JK_MAX_W-1:0] jk_expected(
    input logic [JK_MAX_W-1:0] snap,
    input op_t                 op,
    input logic [JK_MAX_W-1:0] mask
  );
    logic [JK_MAX_W-1:0] res;
    case (op)
      OP_CLR:    res = snap & ~mask;
      OP_SET:    res = snap | mask;
      OP_TOGGLE: res = snap ^ mask;
      default:   res = snap;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/jk_op_arbiter_if.sv
// Request/JK-bank bundle between the requesters, the flop bank and the arbiter.
// master is the environment side (requesters plus bank Q); slave is the arbiter.
interface jk_op_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 4
);

  logic [NUM_REQ-1:0]       req;
  logic [2*NUM_REQ-1:0]     op;
  logic [WIDTH*NUM_REQ-1:0] mask;
  logic [WIDTH-1:0]         Q;
  logic [WIDTH-1:0]         J;
  logic [WIDTH-1:0]         K;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic                     err;
  logic                     busy;

  modport master (
    output req, op, mask, Q,
    input  J, K, gnt, done, err, busy
  );

  modport slave (
    input  req, op, mask, Q,
    output J, K, gnt, done, err, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req at or after pointer, wrapping.
// Works by rotating req down by pointer, taking the lowest set bit, rotating back.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         winner,
  output logic                 valid
);

  logic [N-1:0] rot;
  logic [N-1:0] pick;
  logic [N:0]   seen;

  assign rot     = N'({req, req} >> pointer);
  assign seen[0] = 1'b0;

  for (genvar g = 0; g < N; g++) begin : g_first
    assign pick[g]   = rot[g] & ~seen[g];
    assign seen[g+1] = seen[g] | rot[g];
  end

  assign winner = N'(({pick, pick} << pointer) >> N);
  assign valid  = seen[N];

endmodule

// File: rtl/jk_op_arbiter.sv
// Arbitrates NUM_REQ requesters onto one JK flop bank: drives J/K for one
// clock, then compares the bank's Q against the predicted result.
module jk_op_arbiter
  import jk_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 4
) (
  input logic            clk,
  input logic            rst,
  jk_op_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] win_oh, winner_q, gnt_q;
  logic               win_valid;
  op_t                op_q, sel_op;
  logic [WIDTH-1:0]   mask_q, snap_q, sel_mask;
  logic [WIDTH-1:0]   j_q, k_q, j_d, k_d, exp_q;

  logic [1:0]         op_acc   [NUM_REQ+1];
  logic [WIDTH-1:0]   mask_acc [NUM_REQ+1];
  logic [PW-1:0]      ptr_acc  [NUM_REQ+1];

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (bus.req),
    .pointer (ptr_q),
    .winner  (win_oh),
    .valid   (win_valid)
  );

  // One-hot AND-OR mux of the winner's op/mask and its successor pointer
  assign op_acc[0]   = '0;
  assign mask_acc[0] = '0;
  assign ptr_acc[0]  = ptr_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sel
    assign op_acc[g+1]   = op_acc[g] | (bus.op[2*g +: 2] & {2{win_oh[g]}});
    assign mask_acc[g+1] = mask_acc[g] | (bus.mask[WIDTH*g +: WIDTH] & {WIDTH{win_oh[g]}});
    assign ptr_acc[g+1]  = win_oh[g] ? PW'((g + 1) % NUM_REQ) : ptr_acc[g];
  end

  assign sel_op   = op_t'(op_acc[NUM_REQ]);
  assign sel_mask = mask_acc[NUM_REQ];
  assign ptr_d    = ptr_acc[NUM_REQ];
  assign j_d      = sel_mask & {WIDTH{sel_op == OP_SET || sel_op == OP_TOGGLE}};
  assign k_d      = sel_mask & {WIDTH{sel_op == OP_CLR || sel_op == OP_TOGGLE}};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = DRIVE;
      DRIVE:   state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Grant, J/K and the operation context are captured together on the grant edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      winner_q <= '0;
      gnt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      op_q     <= OP_HOLD;
      mask_q   <= '0;
      snap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            gnt_q    <= win_oh;
            j_q      <= j_d;
            k_q      <= k_d;
            op_q     <= sel_op;
            mask_q   <= sel_mask;
            snap_q   <= bus.Q;
            winner_q <= win_oh;
            ptr_q    <= ptr_d;
          end
        end
        DRIVE: begin
          gnt_q <= '0;
          j_q   <= '0;
          k_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign exp_q    = WIDTH'(jk_expected(JK_MAX_W'(snap_q), op_q, JK_MAX_W'(mask_q)));
  assign bus.J    = j_q;
  assign bus.K    = k_q;
  assign bus.gnt  = gnt_q;
  assign bus.done = (state_q == CHECK) ? winner_q : '0;
  assign bus.err  = (state_q == CHECK) && (bus.Q != exp_q);
  assign bus.busy = (state_q != IDLE);

endmodule

// File: doc/jk_op_arbiter.md
Name: jk_op_arbiter

Overview:
- Shares one WIDTH-bit bank of JK flip-flops between NUM_REQ requesters.
- Each requester asks for one bitwise operation (HOLD/CLR/SET/TOGGLE) on a bit mask. A round-robin arbiter picks one winner, and the block drives J/K for exactly one clock.
- It then checks the flop bank's Q against the predicted result and reports done/err to the winner.
- Sits between the requesting logic and the JK_FF bank; it is the only driver of the bank's J and K.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- WIDTH, 4, width of the JK flop bank.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level, held until that requester's done.
- op  input  2*NUM_REQ  per-requester op code; requester i uses bits [2i+1:2i].
- mask  input  WIDTH*NUM_REQ  per-requester bit mask; requester i uses bits [WIDTH*i +: WIDTH].
- Q  input  WIDTH  present outputs of the JK flop bank.
- J  output  WIDTH  J inputs to the flop bank.
- K  output  WIDTH  K inputs to the flop bank.
- gnt  output  NUM_REQ  one-hot grant, high for the DRIVE cycle only.
- done  output  NUM_REQ  one-hot completion, high for the CHECK cycle only.
- err  output  1  high in the CHECK cycle when Q ≠ expected.
- busy  output  1  high in DRIVE and CHECK.

Behaviour:
- Reset (async, any state):
  - state=IDLE; J=K=0, gnt=0, done=0, err=0, busy=0.
  - Round-robin pointer gives requester 0 highest priority.
  - Latched op/mask/snapshot are cleared.
- Op encoding, applied only to bits where mask=1; unmasked bits always get J=K=0:
  - 00 HOLD: J=0, K=0.
  - 01 CLR: J=0, K=1.
  - 10 SET: J=1, K=0.
  - 11 TOGGLE: J=1, K=1.
- FSM IDLE → DRIVE → CHECK → IDLE. Throughput is one operation per 3 cycles.
- IDLE:
  - req is sampled only in this state.
  - If any req bit is set, the winner is the first set bit at or after the pointer, wrapping.
  - On that posedge: register gnt (one-hot winner) and J/K from the winner's op/mask; latch op, mask and winner; snapshot Q into snap; pointer becomes winner+1 mod NUM_REQ.
  - Go to DRIVE. If no req, stay in IDLE with all outputs 0.
- DRIVE:
  - J/K and gnt are held exactly this one cycle; the flop bank captures at the closing edge.
  - On that edge: J=K=0, gnt=0, go to CHECK.
- CHECK:
  - expected = snap on unmasked bits; on masked bits HOLD → snap, CLR → 0, SET → 1, TOGGLE → ~snap.
  - done[winner]=1 (decoded from the state register and latched winner).
  - err = (Q ≠ expected), valid only in this cycle.
  - Next edge: go to IDLE.
- Latency: req seen at edge n → J/K valid n..n+1 → new Q and done in cycle n+1..n+2.
- Requester rules:
  - A requester deasserts req on the edge that ends its done cycle, or re-requests.
  - Dropping req during DRIVE/CHECK does not abort the operation; it completes and reports done.
  - op/mask changes after grant are ignored because they are latched.
- Simultaneous requests: strict round-robin. With all requests held continuously, grants rotate 0, 1, …, NUM_REQ-1, 0.
- Reset mid-operation: the operation is abandoned with no done or err. J/K fall to 0 immediately; the flop bank state is whatever it captured.
- Flop bank reset or external disturbance during DRIVE: reported as err in CHECK, not masked.
- Widths: op and mask are sliced with fixed indexed part-selects; no arithmetic other than the pointer increment, which wraps at NUM_REQ.

Decomposition:
- Package jk_pkg:
  - op_t enum {OP_HOLD=2'b00, OP_CLR=2'b01, OP_SET=2'b10, OP_TOGGLE=2'b11}.
  - state_t enum {IDLE, DRIVE, CHECK}.
  - Function jk_expected(snap, op, mask) returning the predicted Q, shared by RTL and bench.
- Sub-module rr_arbiter (params N; inputs req and pointer; outputs one-hot winner and valid). Purely combinational; the pointer register lives in jk_op_arbiter.

Test Plan:
- Reset: assert rst mid-DRIVE with J=0101 → same cycle J=K=0, gnt=0, busy=0. After release, first grant with req=11 goes to requester 0.
- SET: Q=0000, req0 op=10 mask=0101 → one cycle J=0101 K=0000, gnt=01. Next cycle Q=0101, done=01, err=0.
- TOGGLE: Q=0101, req1 op=11 mask=1111 → J=K=1111 for one cycle, gnt=10. Then Q=1010, done=10, err=0.
- Fairness: req=11 held continuously with CLR/SET ops → gnt sequence 01, 10, 01, 10, each 3 cycles apart, with no double grant.
- Error: SET mask=0011 while the bank's rst is pulsed during DRIVE → Q=0000, err=1 with done.
- HOLD / abandoned req: op=00 mask=1111 → J=K=0, Q unchanged, done, err=0. req dropped during DRIVE still yields done in CHECK.
